// File: rtl/trace_capture_pkg.sv
// Shared definitions for the trace capture buffer: record layout and FSM encoding.
package trace_pkg;

  localparam int unsigned WIDTH_DFLT = 32;
  localparam int unsigned REC_W      = 3 * WIDTH_DFLT;

  // Record field offsets, matching the test-vector file layout {a, b, y}
  localparam int unsigned A_LSB = 2 * WIDTH_DFLT;
  localparam int unsigned B_LSB = WIDTH_DFLT;
  localparam int unsigned Y_LSB = 0;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

endpackage

// File: rtl/trace_capture_if.sv
// Capture/drain bundle of trace_capture; master is the observing harness, slave the buffer.
interface trace_capture_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 4
);
  logic               arm;
  logic               stop;
  logic               in_valid;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [WIDTH-1:0]   in_y;
  logic               out_valid;
  logic               out_ready;
  logic [3*WIDTH-1:0] out_data;
  logic               out_last;
  logic [AW:0]        count;
  logic               overflow;
  logic               busy;

  modport master (
    output arm, stop, in_valid, in_a, in_b, in_y, out_ready,
    input  out_valid, out_data, out_last, count, overflow, busy
  );

  modport slave (
    input  arm, stop, in_valid, in_a, in_b, in_y, out_ready,
    output out_valid, out_data, out_last, count, overflow, busy
  );
endinterface

// File: rtl/trace_capture_mem.sv
// Record storage: DEPTH x W register array, synchronous write, asynchronous read, no reset.
module trace_mem #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/trace_capture.sv
// Capture buffer for {a,b,y} datapath triples; records during CAPTURE, streams them out in DRAIN.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DFLT,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  trace_capture_if.slave  bus
);

  localparam int unsigned RW = 3 * WIDTH;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   remaining;
  logic [AW:0]   count_next;
  logic [AW-1:0] rd_addr;
  logic [RW-1:0] rec_in;
  logic [RW-1:0] rd_data;
  logic          we;
  logic          xfer;

  assign rec_in     = {bus.in_a, bus.in_b, bus.in_y};
  assign we         = reset && (state == CAPTURE) && bus.in_valid
                      && (bus.count < (AW+1)'(DEPTH));
  assign count_next = bus.count + (AW+1)'(we);
  assign xfer       = bus.out_valid && bus.out_ready;
  // Read port looks one entry ahead while draining; entry 0 is presented at the stop edge
  assign rd_addr    = (state == DRAIN) ? rd_ptr + AW'(1) : '0;
  assign bus.busy   = (state == CAPTURE) || (state == DRAIN);

  trace_mem #(.W(RW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk (clk),
    .we  (we),
    .wa  (wr_ptr),
    .wd  (rec_in),
    .ra  (rd_addr),
    .rd  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      remaining     <= '0;
      bus.count     <= '0;
      bus.overflow  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.arm) begin
            state        <= CAPTURE;
            wr_ptr       <= '0;
            bus.count    <= '0;
            bus.overflow <= 1'b0;
          end
        end
        CAPTURE: begin
          if (we) begin
            wr_ptr    <= wr_ptr + AW'(1);
            bus.count <= count_next;
          end else if (bus.in_valid) begin
            bus.overflow <= 1'b1;
          end
          if (bus.stop) begin
            rd_ptr    <= '0;
            remaining <= count_next;
            if (count_next == '0) begin
              state <= DONE;
            end else begin
              state         <= DRAIN;
              bus.out_valid <= 1'b1;
              bus.out_last  <= (count_next == (AW+1)'(1));
              // Empty buffer: the stop-cycle record has not reached memory yet
              bus.out_data  <= (bus.count == '0) ? rec_in : rd_data;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (remaining > (AW+1)'(1)) begin
              rd_ptr       <= rd_ptr + AW'(1);
              remaining    <= remaining - (AW+1)'(1);
              bus.out_data <= rd_data;
              bus.out_last <= (remaining == (AW+1)'(2));
            end else begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              state         <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Hardware-side capture buffer for the single-cycle processor datapath. It records {a, b, y} operand/result triples from a unit under observation, such as the adder or ALU, into an on-chip buffer.
- After capture stops, it streams the records out over a valid/ready port for dumping to a vector file.
- Each record uses the same 96-bit layout as the team's test-vector files: a in [95:64], b in [63:32], y in [31:0].

Parameters:
WIDTH, 32, operand/result width; record width REC_W = 3*WIDTH
DEPTH, 16, number of buffer entries; must be a power of two
AW, 4, log2(DEPTH); pointer width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
arm  in  1  start a new capture session (clears the buffer)
stop  in  1  end capture and begin draining
in_valid  in  1  a capture record is present this cycle
in_a  in  WIDTH  operand a
in_b  in  WIDTH  operand b
in_y  in  WIDTH  result y
out_valid  out  1  drain record is valid
out_ready  in  1  sink accepts the drain record
out_data  out  REC_W  drain record {a,b,y}, registered
out_last  out  1  current drain record is the final one
count  out  AW+1  records captured this session; not decremented during drain
overflow  out  1  sticky; a record was dropped because the buffer was full
busy  out  1  high in CAPTURE or DRAIN

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE.
  - wr_ptr, rd_ptr, remaining, count, overflow, out_valid, out_last and busy all go to 0; out_data goes to 0.
  - Buffer contents are not reset.
  - Reset has priority over every other input, including mid-capture and mid-drain; out_valid drops at that edge.
- IDLE:
  - arm=1 -> CAPTURE. wr_ptr, count and overflow are cleared.
  - All other inputs are ignored.
- CAPTURE (busy=1):
  - in_valid=1 and count<DEPTH: write {in_a,in_b,in_y} at wr_ptr; wr_ptr+1 (wraps modulo DEPTH); count+1.
  - in_valid=1 and count==DEPTH: the record is dropped and overflow is set to 1. Being full does not end capture.
  - arm is ignored in this state.
  - stop=1 -> DRAIN at the same edge; rd_ptr=0; remaining = count after any same-edge write.
  - A record presented with in_valid in the same cycle as stop is captured if there is room.
  - If the post-write count is 0 -> DONE instead of DRAIN, and out_valid never asserts.
- Entry to DRAIN:
  - out_data <= buffer[0]; out_valid <= 1; out_last <= (remaining==1).
  - Same-edge bypass: when count was 0 and the stop-cycle record is being written, out_data takes the incoming record directly.
  - Latency: out_valid is high in the cycle immediately after the stop edge.
- DRAIN (busy=1):
  - A transfer occurs when out_valid & out_ready.
  - On a transfer with remaining>1: rd_ptr+1, remaining-1, out_data <= next entry, out_last <= (remaining==2).
  - On a transfer with out_last=1: out_valid<=0, out_last<=0, state=DONE.
  - Throughput is one record per cycle when out_ready is held high.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - in_valid, arm and stop are ignored.
- DONE:
  - busy=0; count and overflow hold their values; out_data holds the last record.
  - arm=1 -> CAPTURE with the same clearing as from IDLE.
- Width rules:
  - count saturates at DEPTH and fits in AW+1 bits.
  - Pointers are AW bits and wrap naturally.
  - No arithmetic is performed on record contents.

Decomposition:
- Shared package trace_pkg holds:
  - state encoding IDLE=2'd0, CAPTURE=2'd1, DRAIN=2'd2, DONE=2'd3;
  - REC_W;
  - field offsets A_LSB=2*WIDTH, B_LSB=WIDTH, Y_LSB=0.
- One sub-module, trace_mem: a DEPTH x REC_W register array with one synchronous write port and one asynchronous read port. It has no reset.

Test Plan:
1. Hold reset=0 for 2 cycles with random inputs -> out_valid=0, out_last=0, out_data=0, count=0, overflow=0, busy=0.
2. Arm; capture (1,2,3), (5,7,0xC), (0xFFFFFFFF,1,0); stop; out_ready=1:
   - out_valid is high for exactly 3 consecutive cycles starting the cycle after stop;
   - out_data = 0x000000010000000200000003, then 0x00000005000000070000000C, then 0xFFFFFFFF0000000100000000;
   - out_last is high on the third record only; then DONE, busy=0, count=3.
3. Arm; 18 back-to-back in_valid records with a=i, i=0..17; stop -> count=16, overflow=1; 16 records drained with a=0..15 in order; out_last on a=15; records 16 and 17 never appear.
4. Backpressure: 4 records, with out_ready pattern 1,0,0,1,0,1,1 -> out_data stable through every stall; each record is delivered exactly once, in order.
5. Edge cases on stop:
   - stop with count=0 and in_valid=0 -> DONE next edge; out_valid never asserts.
   - stop with count=0 and in_valid=1 carrying (9,9,0x12) -> exactly one drain record 0x000000090000000900000012 with out_last=1.
6. Reset and re-arm:
   - 5 records captured; reset=0 for 1 cycle after 2 transfers -> out_valid=0 and state IDLE after that edge.
   - Re-arm and capture 1 record -> count=1, overflow=0, correct single drain.
